// File: rtl/ps2_direction_queue.sv
// PS/2 scan-code to one-hot direction queue: synchronises the receiver strobe, decodes
// E0/F0 prefixed arrow keys, filters repeats and reversals and buffers requests in a FIFO.
module ps2_direction_queue #(
    parameter int         DEPTH        = 4,
    parameter bit         ACCEPT_PLAIN = 1'b1,
    parameter logic [3:0] INIT_DIR     = 4'b1000
) (
    input  logic       slow_VGA_CLK,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    input  logic       dir_pop,
    output logic [3:0] dir_req,
    output logic       dir_valid,
    output logic [4:0] fifo_count,
    output logic       overflow
);
    localparam int         PW       = $clog2(DEPTH);
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    function automatic logic [3:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   arrow_dir = 4'b0001;
            8'h6B:   arrow_dir = 4'b0010;
            8'h72:   arrow_dir = 4'b0100;
            8'h74:   arrow_dir = 4'b1000;
            default: arrow_dir = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        opposite = {d[1], d[0], d[3], d[2]};
    endfunction

    logic          ready_p0, ready_p1, ready_p2;
    logic          fill_p0, fill_p1, armed;
    logic          byte_vld;
    state_t        state, state_nx;
    logic [3:0]    make_dir;
    logic          make_vld;
    logic [3:0]    last_dir;
    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [4:0]    count;
    logic          pop_eff, accept, full, push, drop;

    // Stage p0..p2: strobe synchroniser and edge detect. The edge detector is only
    // armed once the synchronised level has been seen low after reset, so a strobe
    // held high through reset release is not mistaken for a new byte.
    always_ff @(posedge slow_VGA_CLK or posedge resetn) begin
        if (resetn) begin
            ready_p0 <= 1'b0;
            ready_p1 <= 1'b0;
            ready_p2 <= 1'b0;
            fill_p0  <= 1'b0;
            fill_p1  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            ready_p0 <= scan_ready;
            ready_p1 <= ready_p0;
            ready_p2 <= ready_p1;
            fill_p0  <= 1'b1;
            fill_p1  <= fill_p0;
            if (fill_p1 && !ready_p1)
                armed <= 1'b1;
        end
    end

    assign byte_vld = armed && ready_p1 && !ready_p2;

    // Prefix decoder: a make request is produced in the byte-event cycle itself.
    always_ff @(posedge slow_VGA_CLK or posedge resetn) begin
        if (resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        make_vld = 1'b0;
        make_dir = arrow_dir(scan_code);
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (scan_code == CODE_EXT)
                        state_nx = EXT;
                    else if (scan_code == CODE_BRK)
                        state_nx = BRK;
                    else begin
                        state_nx = IDLE;
                        make_vld = ACCEPT_PLAIN && (make_dir != 4'b0000);
                    end
                end
                EXT: begin
                    if (scan_code == CODE_BRK)
                        state_nx = EXT_BRK;
                    else if (scan_code == CODE_EXT)
                        state_nx = EXT;
                    else begin
                        state_nx = IDLE;
                        make_vld = (make_dir != 4'b0000);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Filter and FIFO control
    always_comb begin
        rd_ptr_inc = rd_ptr + PW'(1);
        pop_eff    = dir_pop && (count != 5'd0);
        full       = (count == FULL_CNT);
        accept     = make_vld && (make_dir != last_dir) && (make_dir != opposite(last_dir));
        push       = accept && (!full || pop_eff);
        drop       = accept && full && !pop_eff;
    end

    always_ff @(posedge slow_VGA_CLK) begin
        if (push)
            mem[wr_ptr] <= make_dir;
    end

    always_ff @(posedge slow_VGA_CLK or posedge resetn) begin
        if (resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            last_dir <= INIT_DIR;
            overflow <= 1'b0;
            dir_req  <= 4'b0000;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                last_dir <= make_dir;
            end
            if (pop_eff)
                rd_ptr <= rd_ptr_inc;
            if (drop)
                overflow <= 1'b1;
            case ({push, pop_eff})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            // Head register: the next entry, or the incoming request when it lands at the head.
            if (pop_eff) begin
                if (count > 5'd1)
                    dir_req <= mem[rd_ptr_inc];
                else if (push)
                    dir_req <= make_dir;
                else
                    dir_req <= 4'b0000;
            end else if (push && count == 5'd0) begin
                dir_req <= make_dir;
            end
        end
    end

    assign fifo_count = count;
    assign dir_valid  = (count != 5'd0);

endmodule

// File: tb/tb_ps2_direction_queue.sv
// Bench for ps2_direction_queue: directed vector table plus randomized byte/pop traffic
// against a queue-based reference model, on two parameterisations driven in parallel.
module tb_ps2_direction_queue;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_ready = 1'b0;
    logic       dir_pop = 1'b0;
    logic [3:0] req_a, req_b;
    logic       val_a, val_b, ovf_a, ovf_b;
    logic [4:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    ps2_direction_queue #(.DEPTH(4), .ACCEPT_PLAIN(1'b1), .INIT_DIR(4'b1000)) dut_a (
        .slow_VGA_CLK(clk), .resetn(resetn), .scan_code(scan_code), .scan_ready(scan_ready),
        .dir_pop(dir_pop), .dir_req(req_a), .dir_valid(val_a), .fifo_count(cnt_a), .overflow(ovf_a));

    ps2_direction_queue #(.DEPTH(2), .ACCEPT_PLAIN(1'b0), .INIT_DIR(4'b0001)) dut_b (
        .slow_VGA_CLK(clk), .resetn(resetn), .scan_code(scan_code), .scan_ready(scan_ready),
        .dir_pop(dir_pop), .dir_req(req_b), .dir_valid(val_b), .fifo_count(cnt_b), .overflow(ovf_b));

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int         m_depth [2] = '{4, 2};
    bit         m_plain [2] = '{1'b1, 1'b0};
    logic [3:0] m_init  [2] = '{4'b1000, 4'b0001};
    logic [3:0] mq      [2][16];
    int         mcnt    [2];
    logic [3:0] m_popped[2];
    bit         m_ext[2], m_brk[2], m_ovf[2];

    typedef struct {
        int         op;      // 0 byte, 1 pop, 2 reset
        logic [7:0] b;
        bit         p;
        logic       exp_v;
        logic [3:0] exp_r;
        logic [4:0] exp_c;
        logic       exp_o;
    } vec_t;
    vec_t tv[$];

    function automatic logic [3:0] arrow(input logic [7:0] b);
        case (b)
            8'h75:   return 4'b0001;
            8'h6B:   return 4'b0010;
            8'h72:   return 4'b0100;
            8'h74:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] opp(input logic [3:0] d);
        case (d)
            4'b0001: return 4'b0100;
            4'b0100: return 4'b0001;
            4'b0010: return 4'b1000;
            4'b1000: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]     = 0;
            m_popped[k] = m_init[k];
            m_ext[k]    = 1'b0;
            m_brk[k]    = 1'b0;
            m_ovf[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] b, input bit byte_ev, input bit pop);
        logic [3:0] ld, r;
        bit         want, popped;
        int         n0;
        for (int k = 0; k < 2; k++) begin
            n0     = mcnt[k];
            ld     = (n0 > 0) ? mq[k][n0-1] : m_popped[k];
            r      = arrow(b);
            want   = 1'b0;
            popped = 1'b0;
            if (byte_ev) begin
                if (m_brk[k]) begin
                    m_brk[k] = 1'b0;
                    m_ext[k] = 1'b0;
                end else if (b == 8'hE0) begin
                    m_ext[k] = 1'b1;
                end else if (b == 8'hF0) begin
                    m_brk[k] = 1'b1;
                end else begin
                    want     = (r != 4'b0000) && (m_ext[k] || m_plain[k]);
                    m_ext[k] = 1'b0;
                end
            end
            if (want && (r == ld || r == opp(ld)))
                want = 1'b0;
            if (pop && n0 > 0) begin
                m_popped[k] = mq[k][0];
                for (int i = 0; i < 15; i++)
                    mq[k][i] = mq[k][i+1];
                mcnt[k]--;
                popped = 1'b1;
            end
            if (want) begin
                if (n0 < m_depth[k] || popped) begin
                    mq[k][mcnt[k]] = r;
                    mcnt[k]++;
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input string nm);
        logic [9:0] act, exp;
        for (int k = 0; k < 2; k++) begin
            exp = {(mcnt[k] > 0), (mcnt[k] > 0) ? mq[k][0] : 4'b0000, 5'(mcnt[k]), m_ovf[k]};
            if (k == 0)
                act = {val_a, val_a ? req_a : 4'b0000, cnt_a, ovf_a};
            else
                act = {val_b, val_b ? req_b : 4'b0000, cnt_b, ovf_b};
            chk($sformatf("%s_%s", nm, (k == 0) ? "a" : "b"), {22'b0, act}, {22'b0, exp});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_pop, input string nm);
        @(negedge clk);
        scan_code  = b;
        scan_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dir_pop = with_pop;
        check_model({nm, "_pre"});
        @(posedge clk);
        model_step(b, 1'b1, with_pop);
        @(negedge clk);
        dir_pop = 1'b0;
        check_model(nm);
        repeat (3) @(negedge clk);
        check_model({nm, "_hold"});
        scan_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_pop(input string nm);
        @(negedge clk);
        dir_pop = 1'b1;
        @(posedge clk);
        model_step(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        dir_pop = 1'b0;
        check_model(nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #2 resetn = 1'b1;
        #1;
        chk({nm, "_async_a"}, {22'b0, val_a, req_a, cnt_a, ovf_a}, 32'd0);
        chk({nm, "_async_b"}, {22'b0, val_b, req_b, cnt_b, ovf_b}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check_model(nm);
    endtask

    task automatic add(input int op, input logic [7:0] b, input bit p, input logic v,
                       input logic [3:0] r, input logic [4:0] c, input logic o);
        vec_t t;
        t.op = op; t.b = b; t.p = p; t.exp_v = v; t.exp_r = r; t.exp_c = c; t.exp_o = o;
        tv.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [8];
        logic [7:0] b;
        string      nm;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1C, 8'h00};

        // Expected outputs of dut_a (DEPTH 4, plain codes accepted, heading right).
        add(2, 8'h00, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'hE0, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'h75, 0, 1, 4'b0001, 5'd1, 0);
        add(0, 8'hE0, 0, 1, 4'b0001, 5'd1, 0);
        add(0, 8'hF0, 0, 1, 4'b0001, 5'd1, 0);
        add(0, 8'h6B, 0, 1, 4'b0001, 5'd1, 0);
        add(0, 8'h1C, 0, 1, 4'b0001, 5'd1, 0);
        add(1, 8'h00, 0, 0, 4'b0000, 5'd0, 0);
        add(2, 8'h00, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'h6B, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'h74, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'h72, 0, 1, 4'b0100, 5'd1, 0);
        add(0, 8'h6B, 0, 1, 4'b0100, 5'd2, 0);
        add(0, 8'h75, 0, 1, 4'b0100, 5'd3, 0);
        add(0, 8'hE0, 0, 1, 4'b0100, 5'd3, 0);
        add(0, 8'h74, 0, 1, 4'b0100, 5'd4, 0);
        add(0, 8'h75, 1, 1, 4'b0010, 5'd4, 0);
        add(0, 8'h6B, 0, 1, 4'b0010, 5'd4, 1);
        add(1, 8'h00, 0, 1, 4'b0001, 5'd3, 1);
        add(1, 8'h00, 0, 1, 4'b1000, 5'd2, 1);
        add(1, 8'h00, 0, 1, 4'b0001, 5'd1, 1);
        add(1, 8'h00, 0, 0, 4'b0000, 5'd0, 1);
        add(1, 8'h00, 0, 0, 4'b0000, 5'd0, 1);
        add(0, 8'h72, 0, 0, 4'b0000, 5'd0, 1);
        add(0, 8'h74, 0, 1, 4'b1000, 5'd1, 1);
        add(0, 8'h75, 0, 1, 4'b1000, 5'd2, 1);
        add(0, 8'hE0, 0, 1, 4'b1000, 5'd2, 1);
        add(2, 8'h00, 0, 0, 4'b0000, 5'd0, 0);
        add(0, 8'h75, 0, 1, 4'b0001, 5'd1, 0);
        add(0, 8'h74, 1, 1, 4'b1000, 5'd1, 0);
        add(1, 8'h00, 0, 0, 4'b0000, 5'd0, 0);

        model_reset();
        foreach (tv[i]) begin
            nm = $sformatf("vec%0d", i);
            case (tv[i].op)
                0:       send_byte(tv[i].b, tv[i].p, nm);
                1:       do_pop(nm);
                default: do_reset(nm);
            endcase
            chk({nm, "_table"}, {22'b0, val_a, val_a ? req_a : 4'b0000, cnt_a, ovf_a},
                {22'b0, tv[i].exp_v, tv[i].exp_r, tv[i].exp_c, tv[i].exp_o});
        end

        // Strobe held high through reset release must not produce a byte.
        @(negedge clk);
        scan_code  = 8'h75;
        scan_ready = 1'b1;
        do_reset("held_rst");
        repeat (4) @(negedge clk);
        check_model("held_high");
        chk("held_high_cnt_a", {27'b0, cnt_a}, 32'd0);
        scan_ready = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h75, 1'b0, "after_held");
        chk("after_held_cnt_a", {27'b0, cnt_a}, 32'd1);

        for (int n = 0; n < 300; n++) begin
            b = pool[$urandom_range(0, 7)];
            if (b == 8'h00)
                b = 8'($urandom_range(0, 255));
            nm = $sformatf("rnd%0d", n);
            case ($urandom_range(0, 9))
                0, 1:    do_pop(nm);
                2:       send_byte(b, 1'b1, nm);
                3:       if ($urandom_range(0, 9) == 0) do_reset(nm); else send_byte(b, 1'b0, nm);
                default: send_byte(b, 1'b0, nm);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
